spi_paint_master: RTL and testbench

// - SPI initiator that drives the paint-command link: encodes one draw or config command into the
//   2-byte frame that the FPGA SPI receive chain (sync -> spi -> spiFSM -> spiDecode) consumes.
// - Serialises the frame on sck/sdo/cs.
// - Used as an on-FPGA loopback/self-test source and as the link master toward a second paint board.

---
 rtl/paint_pkg.sv | 40 ++++
 rtl/spi_sck_tick.sv | 30 +++
 rtl/spi_paint_master.sv | 155 +++++++++++++++
 tb/tb_spi_paint_master.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/paint_pkg.sv
// Shared paint-link definitions: canvas limits, command bundle,
// SPI frame packing and the SPI transmit state encoding.
package paint_pkg;

   localparam logic [7:0] CANVAS_W     = 8'd160;
   localparam logic [6:0] CANVAS_H     = 7'd120;
   localparam int         CFG_FLAG_BIT = 7;

   typedef struct packed {
      logic       cfg;
      logic [7:0] x;
      logic [6:0] y;
      logic       brush;
      logic [2:0] color;
   } paint_cmd_t;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } spi_tx_state_t;

   // Frame is {packet1, packet2}; packet2 bit 7 marks a config command.
   function automatic logic [15:0] pack_frame(input paint_cmd_t c);
      logic [7:0] p1;
      logic [7:0] p2;
      if (c.cfg) begin
         p1 = {3'b000, c.brush, 1'b0, c.color};
         p2 = '0;
         p2[CFG_FLAG_BIT] = 1'b1;
      end else begin
         p1 = c.x;
         p2 = {1'b0, c.y};
      end
      return {p1, p2};
   endfunction

endpackage

// File: rtl/spi_sck_tick.sv
// Half-period timer for the SPI master.
// Ports: clk, reset (async, active-high), en (count while high,
// cleared while low), tick (high on the last cycle of each half-period).
module spi_sck_tick #(
   parameter int CLK_DIV = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tick
);

   localparam int            CW   = $clog2(CLK_DIV);
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (!en || cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/spi_paint_master.sv
// SPI mode-0 master that packs one draw/config command into a
// 16-bit frame and shifts it out MSB first on sck/sdo with cs low.
// Ports: clk, reset (async, active-high); req_valid/req_ready handshake
// with req_cfg, req_x, req_y, req_brush, req_color; sck, sdo, cs (active
// low) SPI pins; done pulses as cs rises, err pulses on a rejected draw.
module spi_paint_master
   import paint_pkg::*;
#(
   parameter int CLK_DIV = 8,
   parameter int CS_GAP  = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_cfg,
   input  logic [7:0] req_x,
   input  logic [6:0] req_y,
   input  logic       req_brush,
   input  logic [2:0] req_color,
   output logic       sck,
   output logic       sdo,
   output logic       cs,
   output logic       done,
   output logic       err
);

   localparam int            GW       = $clog2(CS_GAP + 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

   spi_tx_state_t state_q, state_n;
   logic [4:0]    edges_q, edges_n;
   logic [GW-1:0] gap_q, gap_n;
   logic [15:0]   sh_q, sh_n;

   paint_cmd_t cmd;
   logic       accept;
   logic       legal;
   logic       tick;
   logic       tick_en;
   logic       busy_n;
   logic       sck_n;
   logic       sdo_n;
   logic       done_n;
   logic       err_n;

   always_comb begin
      cmd.cfg   = req_cfg;
      cmd.x     = req_x;
      cmd.y     = req_y;
      cmd.brush = req_brush;
      cmd.color = req_color;
   end

   // req_ready is only ever high in IDLE.
   assign accept  = req_valid && req_ready;
   assign legal   = cmd.cfg ||
                    ((cmd.x < CANVAS_W) && (cmd.y < CANVAS_H));
   assign tick_en = (state_q == SETUP) || (state_q == SHIFT) ||
                    (state_q == HOLD);

   spi_sck_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .en    (tick_en),
      .tick  (tick)
   );

   always_comb begin
      state_n = state_q;
      edges_n = edges_q;
      gap_n   = gap_q;
      sh_n    = sh_q;
      done_n  = 1'b0;
      err_n   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (legal) begin
                  state_n = SETUP;
                  sh_n    = pack_frame(cmd);
                  edges_n = '0;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         SETUP: begin
            if (tick) state_n = SHIFT;
         end
         SHIFT: begin
            // Even half-periods are sck high; leaving one is a falling
            // edge where sdo advances. The last fall keeps bit 0.
            if (tick) begin
               if (edges_q == 5'd31) begin
                  state_n = HOLD;
               end else begin
                  edges_n = edges_q + 5'd1;
                  if (!edges_q[0] && edges_q != 5'd30)
                     sh_n = {sh_q[14:0], 1'b0};
               end
            end
         end
         HOLD: begin
            if (tick) begin
               state_n = GAP;
               gap_n   = '0;
               done_n  = 1'b1;
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) begin
               state_n = IDLE;
               gap_n   = '0;
            end else begin
               gap_n = gap_q + GW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n == SETUP) || (state_n == SHIFT) ||
               (state_n == HOLD);
      sck_n  = (state_n == SHIFT) && !edges_n[0];
      sdo_n  = busy_n && sh_n[15];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         edges_q   <= '0;
         gap_q     <= '0;
         sh_q      <= '0;
         req_ready <= 1'b0;
         cs        <= 1'b1;
         sck       <= 1'b0;
         sdo       <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state_q   <= state_n;
         edges_q   <= edges_n;
         gap_q     <= gap_n;
         sh_q      <= sh_n;
         req_ready <= (state_n == IDLE);
         cs        <= !busy_n;
         sck       <= sck_n;
         sdo       <= sdo_n;
         done      <= done_n;
         err       <= err_n;
      end
   end

endmodule

// File: tb/tb_spi_paint_master.sv
// Directed + randomized bench for spi_paint_master with an SPI
// pin monitor and a field-level frame model.
module tb_spi_paint_master;

   localparam int K = 8;
   localparam int G = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_cfg = 1'b0;
   logic [7:0] req_x = '0;
   logic [6:0] req_y = '0;
   logic       req_brush = 1'b0;
   logic [2:0] req_color = '0;
   logic       sck, sdo, cs, done, err;

   spi_paint_master #(
      .CLK_DIV (K),
      .CS_GAP  (G)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_cfg   (req_cfg),
      .req_x     (req_x),
      .req_y     (req_y),
      .req_brush (req_brush),
      .req_color (req_color),
      .sck       (sck),
      .sdo       (sdo),
      .cs        (cs),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   // ---------------- pin monitor (samples on falling clk) -------------
   int          cyc = 0;
   logic        prev_sck = 1'b0, prev_cs = 1'b1, prev_sdo = 1'b0;
   int          sdo_age = 0, since_rise = 1000, run_len = 0, cs_len = 0;
   logic [15:0] fr = '0;
   int          rises = 0;
   int          frames_cnt = 0, last_rises = 0, last_cs_len = 0;
   logic [15:0] last_frame = '0;
   int          done_cnt = 0, err_cnt = 0, done_bad = 0;
   int          setup_bad = 0, hold_bad = 0;
   int          hp_min = 1000, hp_max = 0;
   int          acc_q[$];

   wire rise_s = sck && !prev_sck;
   wire fall_s = !sck && prev_sck;
   wire sdo_chg = (sdo != prev_sdo);
   wire hp_ev = !cs && (fall_s || (rise_s && rises != 0));

   always @(negedge clk) begin
      cyc      <= cyc + 1;
      prev_sck <= sck;
      prev_cs  <= cs;
      prev_sdo <= sdo;
      if (req_valid && req_ready) acc_q.push_back(cyc);
      sdo_age <= sdo_chg ? 1 : sdo_age + 1;
      run_len <= (sck != prev_sck) ? 1 : run_len + 1;
      if (rise_s) since_rise <= 1;
      else if (since_rise < 1000) since_rise <= since_rise + 1;
      if (cs) since_rise <= 1000;
      if (!cs) begin
         cs_len <= cs_len + 1;
         if (rise_s) begin
            fr    <= {fr[14:0], sdo};
            rises <= rises + 1;
            if (sdo_chg || sdo_age < K) setup_bad <= setup_bad + 1;
         end
         if (sdo_chg && since_rise < K) hold_bad <= hold_bad + 1;
         if (hp_ev) begin
            if (run_len < hp_min) hp_min <= run_len;
            if (run_len > hp_max) hp_max <= run_len;
         end
      end
      if (!cs && prev_cs) begin
         fr     <= '0;
         rises  <= 0;
         cs_len <= 1;
      end
      if (cs && !prev_cs) begin
         frames_cnt  <= frames_cnt + 1;
         last_frame  <= fr;
         last_rises  <= rises;
         last_cs_len <= cs_len;
      end
      if (done) begin
         done_cnt <= done_cnt + 1;
         if (!(cs && !prev_cs)) done_bad <= done_bad + 1;
      end
      if (err) err_cnt <= err_cnt + 1;
   end

   // ---------------- reference model ----------------------------------
   function automatic logic [15:0] model_frame(
      input logic c, input logic [7:0] x, input logic [6:0] y,
      input logic b, input logic [2:0] col);
      int v;
      if (c) v = int'(b) * 4096 + int'(col) * 256 + 128;
      else   v = int'(x) * 256 + int'(y);
      return v[15:0];
   endfunction

   function automatic bit model_legal(
      input logic c, input logic [7:0] x, input logic [6:0] y);
      return c || (int'(x) < 160 && int'(y) < 120);
   endfunction

   // ---------------- helpers ------------------------------------------
   int passed = 0;
   int total  = 0;
   int fails  = 0;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic c, input logic [7:0] x,
                          input logic [6:0] y, input logic b,
                          input logic [2:0] col);
      req_cfg   = c;
      req_x     = x;
      req_y     = y;
      req_brush = b;
      req_color = col;
      req_valid = 1'b1;
   endtask

   task automatic wait_accept(input string tag);
      bit ok;
      ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (req_ready === 1'b1) begin
            ok = 1;
            break;
         end
      end
      @(posedge clk);
      #1;
      if (!ok) check({tag, "_accept_timeout"}, 0, 1);
   endtask

   task automatic wait_frame(input string tag, input int n0);
      bit ok;
      ok = 0;
      for (int i = 0; i < 700; i++) begin
         step();
         if (frames_cnt > n0) begin
            ok = 1;
            break;
         end
      end
      check({tag, "_frame_seen"}, 32'(ok), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- directed + random sequence -----------------------
   initial begin
      int          n0, d0, e0, bad, diff;
      logic        c, b;
      logic [7:0]  x;
      logic [6:0]  y;
      logic [2:0]  col;
      logic [15:0] fa, fb;

      // reset state
      repeat (3) step();
      check("reset_outputs", {26'd0, req_ready, cs, sck, sdo, done, err},
            32'b010000);
      reset = 1'b0;
      step();
      check("ready_after_reset", 32'(req_ready), 1);

      // corner draw
      n0 = frames_cnt; d0 = done_cnt;
      present(1'b0, 8'd159, 7'd119, 1'b0, 3'd0);
      wait_accept("draw_max");
      req_valid = 1'b0;
      wait_frame("draw_max", n0);
      check("draw_max_frame", 32'(last_frame), 32'h9F77);
      check("draw_max_rises", 32'(last_rises), 16);
      check("draw_max_cs_low", 32'(last_cs_len), 34 * K);
      check("draw_max_done", 32'(done_cnt - d0), 1);
      check("draw_max_dec_x", 32'(last_frame[15:8]), 159);
      check("draw_max_dec_y", 32'(last_frame[6:0]), 119);

      // config
      n0 = frames_cnt;
      present(1'b1, 8'd0, 7'd0, 1'b1, 3'd5);
      wait_accept("cfg");
      req_valid = 1'b0;
      wait_frame("cfg", n0);
      check("cfg_frame", 32'(last_frame),
            32'(model_frame(1'b1, 8'd0, 7'd0, 1'b1, 3'd5)));
      check("cfg_flag", 32'(last_frame[7]), 1);
      check("cfg_brush", 32'(last_frame[12]), 1);
      check("cfg_color", 32'(last_frame[10:8]), 5);

      // out-of-range draw
      n0 = frames_cnt; e0 = err_cnt; d0 = done_cnt;
      present(1'b0, 8'd160, 7'd0, 1'b0, 3'd0);
      wait_accept("reject");
      check("reject_err_next_cycle", 32'(err), 1);
      req_valid = 1'b0;
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         step();
         if (cs !== 1'b1 || req_ready !== 1'b1) bad++;
      end
      check("reject_idle_300", 32'(bad), 0);
      check("reject_err_count", 32'(err_cnt - e0), 1);
      check("reject_no_frame", 32'(frames_cnt - n0), 0);
      check("reject_no_done", 32'(done_cnt - d0), 0);

      // back-to-back with held req_valid
      acc_q.delete();
      n0 = frames_cnt;
      x = 8'($urandom_range(0, 159)); y = 7'($urandom_range(0, 119));
      fa = model_frame(1'b0, x, y, 1'b0, 3'd0);
      present(1'b0, x, y, 1'b0, 3'd0);
      wait_accept("b2b_a");
      b = 1'($urandom_range(0, 1)); col = 3'($urandom_range(0, 7));
      fb = model_frame(1'b1, 8'd0, 7'd0, b, col);
      present(1'b1, 8'd0, 7'd0, b, col);
      wait_accept("b2b_b");
      req_valid = 1'b0;
      diff = (acc_q.size() >= 2) ? acc_q[1] - acc_q[0] : -1;
      check("b2b_accept_gap", 32'(diff), 1 + 34 * K + G);
      wait_frame("b2b", n0 + 1);
      check("b2b_frames", 32'(frames_cnt - n0), 2);
      check("b2b_frame_b", 32'(last_frame), 32'(fb));
      check("b2b_frame_a_model_differs", 32'(fa != fb), 1);

      // inputs scrambled while the frame is on the wire
      n0 = frames_cnt;
      x = 8'($urandom_range(0, 159)); y = 7'($urandom_range(0, 119));
      present(1'b0, x, y, 1'b0, 3'd0);
      wait_accept("scramble");
      req_valid = 1'b0;
      for (int i = 0; i < 700; i++) begin
         step();
         req_cfg   = 1'($urandom);
         req_x     = 8'($urandom);
         req_y     = 7'($urandom);
         req_brush = 1'($urandom);
         req_color = 3'($urandom);
         if (frames_cnt > n0) break;
      end
      check("scramble_frame", 32'(last_frame),
            32'(model_frame(1'b0, x, y, 1'b0, 3'd0)));

      // reset in the 7th sck high phase
      n0 = frames_cnt; d0 = done_cnt;
      present(1'b0, 8'd77, 7'd33, 1'b0, 3'd0);
      wait_accept("abort");
      req_valid = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (rises == 7 && !cs && sck) break;
         step();
      end
      #2;
      reset = 1'b1;
      #1;
      check("abort_pins_now", {30'd0, cs, sck}, 32'b10);
      repeat (3) step();
      reset = 1'b0;
      repeat (3) step();
      check("abort_no_done", 32'(done_cnt - d0), 0);
      check("abort_rises", 32'(last_rises), 7);
      n0 = frames_cnt;
      present(1'b0, 8'd1, 7'd2, 1'b0, 3'd0);
      wait_accept("post_abort");
      req_valid = 1'b0;
      wait_frame("post_abort", n0);
      check("post_abort_frame", 32'(last_frame), 32'h0102);
      check("post_abort_dec_x", 32'(last_frame[15:8]), 1);
      check("post_abort_dec_y", 32'(last_frame[6:0]), 2);

      // random commands, some out of range
      for (int t = 0; t < 8; t++) begin
         c   = 1'($urandom_range(0, 1));
         x   = 8'($urandom_range(0, 180));
         y   = 7'($urandom_range(0, 127));
         b   = 1'($urandom_range(0, 1));
         col = 3'($urandom_range(0, 7));
         n0 = frames_cnt; d0 = done_cnt; e0 = err_cnt;
         present(c, x, y, b, col);
         wait_accept("rand");
         req_valid = 1'b0;
         if (model_legal(c, x, y)) begin
            wait_frame("rand", n0);
            check("rand_frame", 32'(last_frame),
                  32'(model_frame(c, x, y, b, col)));
            check("rand_done", 32'(done_cnt - d0), 1);
         end else begin
            repeat (3) step();
            check("rand_err", 32'(err_cnt - e0), 1);
            check("rand_no_frame", 32'(frames_cnt - n0), 0);
         end
      end

      // whole-run timing properties
      check("half_period_min", 32'(hp_min), K);
      check("half_period_max", 32'(hp_max), K);
      check("sdo_setup", 32'(setup_bad), 0);
      check("sdo_hold", 32'(hold_bad), 0);
      check("done_alignment", 32'(done_bad), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
